led_pattern_seq: RTL and testbench
==================================

# led_pattern_seq

Multi-channel LED pattern sequencer: each channel holds a runtime-writable PATTERN_LEN-bit pattern, and a shared prescaled step counter drives the current pattern bit onto that channel's LED output. It supports free-running repeat, one-shot playback, forced off and forced on. It sits between the board top level (which owns the 16 MHz clock and pad tie-offs) and any control logic that reprograms LED patterns at runtime.

## Interface
- CHANNELS, 1: number of LED channels (1..16).
- PATTERN_LEN, 32: pattern bits per channel (2..64); need not be a power of two.
- TICK_DIV, 2097152: CLK cycles per pattern step (2..2^26); 2^21 gives ≈131 ms at 16 MHz.
- INIT_PATTERN, 32'h0000_F00A: reset value loaded into every channel's pattern; truncated or zero-extended to PATTERN_LEN.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- mode  in  2  0 = REPEAT, 1 = ONESHOT, 2 = OFF, 3 = ON.
- start  in  1  one-cycle pulse; starts or restarts ONESHOT playback.
- wr_en  in  1  pattern write strobe.
- wr_ch  in  4  target channel of the write.
- wr_data  in  PATTERN_LEN  new pattern; bit i is shown during step i.
- LED  out  CHANNELS  registered LED drive, 1 = lit.
- busy  out  1  ONESHOT playback in progress.
- step  out  clog2(PATTERN_LEN)  current step index.
- tick  out  1  one-cycle pulse on each step advance.

## Operation
- Prescaler `div` counts 0..TICK_DIV-1. The cycle where div == TICK_DIV-1 asserts tick, and div wraps to 0.
- `step` advances on tick. It wraps from PATTERN_LEN-1 to 0 in REPEAT mode.
- Per-channel pattern registers are reloaded by wr_en. A write with wr_ch ≥ CHANNELS is ignored.
- LED[c] is registered each cycle:
  - REPEAT: pat[c][step].
  - ONESHOT: pat[c][step] when busy, else 0.
  - OFF: 0.
  - ON: 1.
- ONESHOT:
  - On start, div and step are cleared to 0 and busy is set to 1.
  - On the tick where step == PATTERN_LEN-1, busy clears and step returns to 0.
  - start while busy restarts from step 0.
  - start in any other mode is ignored.
- Mode change:
  - Takes effect on the next edge.
  - Leaving ONESHOT clears busy.
  - div and step keep running in every mode; they are not reset by a mode change.
- Simultaneous wr_en and tick: the step advances and the new pattern is written on the same edge. The next LED value uses the new pattern at the new step.
- Simultaneous start and tick: start wins, so step is 0 and div is 0.
- All counters use plain unsigned arithmetic and never exceed their terminal values.

## Timing
- On RST:
  - div = 0, step = 0, tick = 0, busy = 0, LED = 0.
  - Every pattern register = INIT_PATTERN.
  - RST mid-playback aborts it immediately (asynchronous).
- After RST deasserts:
  - First tick occurs at cycle TICK_DIV-1.
  - LED reflects step-0 bits from cycle 1.
- LED latency is 1 cycle after the step, mode or pattern register it depends on changes.
- tick is high exactly 1 cycle per TICK_DIV cycles.
- Write latency: pattern register updated at edge N; LED reflects it at edge N+1.
- ONESHOT:
  - busy rises 1 cycle after start.
  - busy is high for PATTERN_LEN·TICK_DIV cycles.

## Configuration
- LED_PATTERN_SEQ_PWM_EN defined:
  - Adds input `bright` (4 bits).
  - Adds a free-running 4-bit PWM counter `pwm`, reset to 0.
  - Each LED output is its normal value ANDed with (pwm < bright).
  - bright = 0 forces dark; bright = 15 gives 15/16 duty. ON mode is dimmed as well.
- Undefined: no `bright` port, no PWM counter; LED is the undimmed value.

## Test plan
- Reset: assert RST mid-count with TICK_DIV=4 -> LED=0, busy=0, tick=0, step=0 in the same cycle; patterns read back INIT_PATTERN behaviour after release.
- REPEAT, TICK_DIV=4, PATTERN_LEN=4, CHANNELS=2, write ch0=4'b0101, ch1=4'b0011 -> LED[0] sequence 1,0,1,0 and LED[1] sequence 1,1,0,0, each held 4 cycles; pattern repeats after 16 cycles; tick every 4th cycle.
- ONESHOT, pattern 4'b1111 -> busy high for exactly 16 cycles starting 1 cycle after start, LED=1 throughout, then LED=0 and busy=0; a second start at step 2 restarts at step 0 with busy held high.
- Write wr_ch=5 with CHANNELS=2 -> no pattern changes. Write coinciding with tick -> new pattern shown at the new step the following cycle.
- OFF/ON: OFF -> LED=0; ON -> LED all 1 within 1 cycle; switching from ONESHOT to REPEAT mid-run clears busy next cycle.
- With LED_PATTERN_SEQ_PWM_EN, ON mode, bright=4 -> each LED is high 4 of every 16 cycles; bright=0 -> constantly 0.

Source files
------------

// File: rtl/led_pattern_seq.sv
// led_pattern_seq
//   Multi-channel LED pattern sequencer. Every channel holds a runtime-writable
//   PATTERN_LEN-bit pattern. A shared prescaler produces one step per TICK_DIV
//   clocks, and each channel's LED shows the pattern bit of the current step.
//   Modes: 0 REPEAT, 1 ONESHOT, 2 OFF, 3 ON.
//
// Optional feature: define LED_PATTERN_SEQ_PWM_EN to add a 4-bit `bright` input.
//   A free-running 4-bit PWM counter then dims every LED output, ON mode
//   included.
//
// Ports
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous reset, active high
//   mode     in   [1:0] playback mode
//   start    in   one-cycle pulse; starts or restarts ONESHOT playback
//   wr_en    in   pattern write strobe
//   wr_ch    in   [3:0] target channel; channels >= CHANNELS are ignored
//   wr_data  in   [PATTERN_LEN-1:0] new pattern; bit i is shown during step i
//   bright   in   [3:0] PWM duty in sixteenths (only with LED_PATTERN_SEQ_PWM_EN)
//   LED      out  [CHANNELS-1:0] registered LED drive, 1 = lit
//   busy     out  ONESHOT playback in progress
//   step     out  current step index
//   tick     out  one-cycle pulse in the cycle before each step advance
module led_pattern_seq #(
    parameter int          CHANNELS     = 1,
    parameter int          PATTERN_LEN  = 32,
    parameter int          TICK_DIV     = 2097152,
    parameter logic [63:0] INIT_PATTERN = 64'h0000_0000_0000_F00A
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [1:0]                     mode,
    input  logic                           start,
    input  logic                           wr_en,
    input  logic [3:0]                     wr_ch,
    input  logic [PATTERN_LEN-1:0]         wr_data,
`ifdef LED_PATTERN_SEQ_PWM_EN
    input  logic [3:0]                     bright,
`endif
    output logic [CHANNELS-1:0]            LED,
    output logic                           busy,
    output logic [$clog2(PATTERN_LEN)-1:0] step,
    output logic                           tick
);

    localparam int SW = $clog2(PATTERN_LEN);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(PATTERN_LEN - 1);

    localparam logic [1:0] MODE_REPEAT  = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_OFF     = 2'd2;

    logic [DW-1:0]                         div_q, div_d;
    logic [SW-1:0]                         step_q, step_d;
    logic                                  busy_q, busy_d;
    logic [CHANNELS-1:0]                   led_q, led_d;
    logic [CHANNELS-1:0][PATTERN_LEN-1:0]  pat_q;
    logic                                  tick_w;
    logic                                  restart_w;

    assign tick_w    = (div_q == DIV_LAST);
    // start only has meaning in ONESHOT; elsewhere it is dropped.
    assign restart_w = start && (mode == MODE_ONESHOT);

    // Prescaler, step counter and busy flag.
    always_comb begin
        div_d  = div_q + DW'(1);
        step_d = step_q;
        busy_d = busy_q;
        if (tick_w) begin
            div_d = '0;
            if (step_q == STEP_LAST) begin
                step_d = '0;
                busy_d = 1'b0;
            end else begin
                step_d = step_q + SW'(1);
            end
        end
        // A restart overrides a coincident tick: the run begins at step 0.
        if (restart_w) begin
            div_d  = '0;
            step_d = '0;
            busy_d = 1'b1;
        end
        if (mode != MODE_ONESHOT) busy_d = 1'b0;
    end

`ifdef LED_PATTERN_SEQ_PWM_EN
    logic [3:0] pwm_q;
    logic       pwm_lit;

    assign pwm_lit = (pwm_q < bright);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pwm_q <= '0;
        else     pwm_q <= pwm_q + 4'd1;
    end
`endif

    // LED next value: uses the current (pre-edge) pattern, step and busy, so a
    // pattern written on a tick edge shows at the new step one cycle later.
    always_comb begin
        led_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode)
                MODE_REPEAT:  led_d[c] = pat_q[c][step_q];
                MODE_ONESHOT: led_d[c] = busy_q & pat_q[c][step_q];
                MODE_OFF:     led_d[c] = 1'b0;
                default:      led_d[c] = 1'b1;
            endcase
        end
`ifdef LED_PATTERN_SEQ_PWM_EN
        led_d = led_d & {CHANNELS{pwm_lit}};
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            led_q  <= '0;
        end else begin
            div_q  <= div_d;
            step_q <= step_d;
            busy_q <= busy_d;
            led_q  <= led_d;
        end
    end

    // Pattern registers; a write to a channel that does not exist matches none.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < CHANNELS; c++) pat_q[c] <= INIT_PATTERN[PATTERN_LEN-1:0];
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_en && (wr_ch == 4'(c))) pat_q[c] <= wr_data;
            end
        end
    end

    assign LED  = led_q;
    assign busy = busy_q;
    assign step = step_q;
    assign tick = tick_w;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq with CHANNELS=2, PATTERN_LEN=4, TICK_DIV=4.
// The model keeps "cycles since the phase origin" (reset or accepted start)
// and derives step, tick and busy arithmetically from it; a compare process
// checks every output on every non-reset cycle. Directed sequences carry
// hand-computed literal expectations.
module tb_led_pattern_seq;

    localparam int CH = 2;
    localparam int PL = 4;
    localparam int TD = 4;
    localparam logic [63:0] INIT = 64'h0000_0000_0000_F00A;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic [3:0]    wr_ch = 4'd0;
    logic [PL-1:0] wr_data = '0;
`ifdef LED_PATTERN_SEQ_PWM_EN
    logic [3:0]    bright = 4'd15;
`endif
    logic [CH-1:0] LED;
    logic          busy;
    logic [1:0]    step;
    logic          tick;

    int checks = 0;
    int errors = 0;

    led_pattern_seq #(
        .CHANNELS(CH), .PATTERN_LEN(PL), .TICK_DIV(TD), .INIT_PATTERN(INIT)
    ) dut (
        .CLK(CLK), .RST(RST), .mode(mode), .start(start),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
`ifdef LED_PATTERN_SEQ_PWM_EN
        .bright(bright),
`endif
        .LED(LED), .busy(busy), .step(step), .tick(tick)
    );

    always #5 CLK = ~CLK;

    // ---------------- model ----------------
    int            t;       // cycles since phase origin
    int            cyc;     // cycles since reset (PWM phase)
    int            ecount;  // edges since reset release
    logic          busy_m;
    logic [CH-1:0] led_m;
    logic [PL-1:0] pat_m [CH];

    function automatic logic led_val(input int c);
        int   s;
        logic v;
        s = (t / TD) % PL;
        case (mode)
            2'd0:    v = pat_m[c][s];
            2'd1:    v = busy_m & pat_m[c][s];
            2'd2:    v = 1'b0;
            default: v = 1'b1;
        endcase
`ifdef LED_PATTERN_SEQ_PWM_EN
        if ((cyc % 16) >= int'(bright)) v = 1'b0;
`endif
        return v;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            t      <= 0;
            cyc    <= 0;
            ecount <= 0;
            busy_m <= 1'b0;
            led_m  <= '0;
            for (int c = 0; c < CH; c++) pat_m[c] <= INIT[PL-1:0];
        end else begin
            ecount <= ecount + 1;
            cyc    <= cyc + 1;
            for (int c = 0; c < CH; c++) led_m[c] <= led_val(c);
            if (mode == 2'd1 && start) begin
                t      <= 0;
                busy_m <= 1'b1;
            end else begin
                t      <= t + 1;
                busy_m <= busy_m && (mode == 2'd1) && (t + 1 < PL * TD);
            end
            for (int c = 0; c < CH; c++)
                if (wr_en && int'(wr_ch) == c) pat_m[c] <= wr_data;
        end
    end

    task automatic expect_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            expect_eq("led",  LED,  led_m);
            expect_eq("busy", busy, busy_m);
            expect_eq("step", step, (t / TD) % PL);
            expect_eq("tick", tick, (t % TD) == TD - 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic goto(input int k);
        while (ecount < k) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_reset_outputs();
        expect_eq("rst_led",  LED,  0);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_step", step, 0);
        expect_eq("rst_tick", tick, 0);
    endtask

    // Called right after reset release in REPEAT mode: INIT truncates to 4'b1010.
    task automatic init_check();
        goto(2); @(negedge CLK); expect_eq("tick_early", tick, 0);
        goto(3); @(negedge CLK); expect_eq("tick_first", tick, 1);
`ifndef LED_PATTERN_SEQ_PWM_EN
        goto(4); @(negedge CLK); expect_eq("init_led_s0", LED, 2'b00);
        goto(5); @(negedge CLK); expect_eq("init_led_s1", LED, 2'b11);
`endif
    endtask

    logic [1:0] rep_led [4];

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // LED value per step for ch0=4'b0101, ch1=4'b0011: {LED1,LED0}
        rep_led[0] = 2'b11;
        rep_led[1] = 2'b10;
        rep_led[2] = 2'b01;
        rep_led[3] = 2'b00;

        repeat (3) @(posedge CLK);
        #1;
        expect_reset_outputs();
        RST = 1'b0;
        init_check();

        // Asynchronous reset mid-count (step 1, LED lit)
        goto(6);
        RST = 1'b1;
        #1;
        expect_reset_outputs();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // REPEAT with new patterns
        wr_en = 1'b1; wr_ch = 4'd0; wr_data = 4'b0101;
        goto(1); wr_ch = 4'd1; wr_data = 4'b0011;
        goto(2); wr_en = 1'b0;
        for (int k = 3; k <= 20; k++) begin
            goto(k); @(negedge CLK);
`ifndef LED_PATTERN_SEQ_PWM_EN
            expect_eq("rep_led", LED, rep_led[((k - 1) / 4) % 4]);
`endif
            expect_eq("rep_tick", tick, (k % 4) == 3);
        end

        // Write to a channel that does not exist
        goto(21); wr_en = 1'b1; wr_ch = 4'd5; wr_data = 4'b0000;
        goto(22); wr_en = 1'b0;
        // Write coinciding with tick (cycle 23: step 1, last div)
        goto(23); wr_en = 1'b1; wr_ch = 4'd0; wr_data = 4'b1010;
        @(negedge CLK);
`ifndef LED_PATTERN_SEQ_PWM_EN
        expect_eq("bad_ch_led", LED, 2'b10);
`endif
        expect_eq("wr_tick", tick, 1);
        goto(24); wr_en = 1'b0;
        goto(25); @(negedge CLK);
`ifndef LED_PATTERN_SEQ_PWM_EN
        expect_eq("wr_tick_led", LED, 2'b00);
`endif

        // ONESHOT with all-ones patterns
        goto(26); wr_en = 1'b1; wr_ch = 4'd0; wr_data = 4'b1111;
        goto(27); wr_ch = 4'd1;
        goto(28); wr_en = 1'b0;
        goto(30); mode = 2'd1; start = 1'b1;
        goto(31); start = 1'b0;
        for (int k = 31; k <= 48; k++) begin
            goto(k); @(negedge CLK);
            expect_eq("os_busy", busy, (k >= 31 && k <= 46));
`ifndef LED_PATTERN_SEQ_PWM_EN
            expect_eq("os_led", LED, (k >= 32 && k <= 47) ? 2'b11 : 2'b00);
`endif
        end

        // Restart at step 2
        goto(50); start = 1'b1;
        goto(51); start = 1'b0;
        goto(60); start = 1'b1;
        @(negedge CLK); expect_eq("pre_restart_step", step, 2);
        goto(61); start = 1'b0;
        @(negedge CLK);
        expect_eq("restart_step", step, 0);
        expect_eq("restart_busy", busy, 1);
        goto(76); @(negedge CLK); expect_eq("restart_busy_end", busy, 1);
        goto(77); @(negedge CLK); expect_eq("restart_done", busy, 0);

        // Leaving ONESHOT mid-run
        goto(80); start = 1'b1;
        goto(81); start = 1'b0;
        goto(85); mode = 2'd0;
        @(negedge CLK); expect_eq("leave_busy_hold", busy, 1);
        goto(86); @(negedge CLK); expect_eq("leave_busy_clr", busy, 0);

        // OFF then ON
        goto(90); mode = 2'd2;
        goto(91); @(negedge CLK); expect_eq("off_led", LED, 2'b00);
        goto(92); wr_en = 1'b1; wr_ch = 4'd0; wr_data = 4'b0000;
        goto(93); wr_ch = 4'd1;
        goto(94); wr_en = 1'b0;
        goto(95); mode = 2'd3;
`ifndef LED_PATTERN_SEQ_PWM_EN
        goto(96); @(negedge CLK); expect_eq("on_led", LED, 2'b11);
`endif
        goto(97); start = 1'b1;
        goto(98); start = 1'b0;
        @(negedge CLK); expect_eq("on_start_ignored", busy, 0);

`ifdef LED_PATTERN_SEQ_PWM_EN
        begin
            int n0, n1;
            goto(100); bright = 4'd4;
            n0 = 0; n1 = 0;
            for (int k = 101; k <= 116; k++) begin
                goto(k); @(negedge CLK);
                n0 += int'(LED[0]); n1 += int'(LED[1]);
            end
            expect_eq("pwm4_ch0", n0, 4);
            expect_eq("pwm4_ch1", n1, 4);
            goto(120); bright = 4'd0;
            n0 = 0; n1 = 0;
            for (int k = 121; k <= 136; k++) begin
                goto(k); @(negedge CLK);
                n0 += int'(LED[0]); n1 += int'(LED[1]);
            end
            expect_eq("pwm0_ch0", n0, 0);
            expect_eq("pwm0_ch1", n1, 0);
            bright = 4'd15;
        end
`endif

        // Reset aborting a ONESHOT run, then INIT patterns are back
        goto(140); mode = 2'd0; wr_en = 1'b1; wr_ch = 4'd0; wr_data = 4'b1111;
        goto(141); wr_ch = 4'd1;
        goto(142); wr_en = 1'b0;
        goto(144); mode = 2'd1; start = 1'b1;
        goto(145); start = 1'b0;
        goto(151);
        @(negedge CLK); expect_eq("pre_abort_busy", busy, 1);
        @(posedge CLK); #1;
        RST = 1'b1;
        mode = 2'd0;
        #1;
        expect_reset_outputs();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        init_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
